// File: rtl/icap_read.sv
// ICAPE2 configuration-register read sequencer: header, read window, desync.
// Optional macro ICAP_READ_BITSWAP_EN bit-reverses each byte on icap_i/icap_o for real ICAPE2 silicon.
module icap_read #(
   parameter int RD_LAT = 4
) (
   input  logic        c,
   input  logic        rst_n,
   input  logic        start,
   input  logic [4:0]  addr,
   output logic        busy,
   output logic        valid,
   output logic [31:0] o,
   output logic        icap_csib,
   output logic        icap_rdwrb,
   output logic [31:0] icap_i,
   input  logic [31:0] icap_o
);

   typedef enum logic [2:0] {IDLE, HDR, SW_RD, RD, SW_WR, DSYNC, DONE} state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [4:0]  r_addr;
   logic [31:0] r_rdData;
   logic [31:0] w_icapOData;

`ifdef ICAP_READ_BITSWAP_EN
   function automatic logic [31:0] byteRev(input logic [31:0] w);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 4; b++)
         for (int i = 0; i < 8; i++)
            r[8*b+i] = w[8*b+7-i];
      return r;
   endfunction

   function automatic logic [31:0] pinWord(input logic [31:0] w);
      return byteRev(w);
   endfunction
`else
   function automatic logic [31:0] pinWord(input logic [31:0] w);
      return w;
   endfunction
`endif

   // Sync, type-1 read of the requested register, then two NOOPs
   function automatic logic [31:0] hdrWord(input logic [3:0] idx, input logic [4:0] a);
      case (idx)
         4'd0:    return 32'hFFFF_FFFF;
         4'd1:    return 32'hAA99_5566;
         4'd3:    return 32'h2800_0001 | {14'd0, a, 13'd0};
         default: return 32'h2000_0000;
      endcase
   endfunction

   function automatic logic [31:0] dsyncWord(input logic [3:0] idx);
      case (idx)
         4'd0:    return 32'h3000_8001;
         4'd1:    return 32'h0000_000D;
         default: return 32'h2000_0000;
      endcase
   endfunction

   assign w_icapOData = pinWord(icap_o);

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_rdData   <= '0;
         busy       <= 1'b0;
         valid      <= 1'b0;
         o          <= '0;
         icap_csib  <= 1'b1;
         icap_rdwrb <= 1'b0;
         icap_i     <= '0;
      end else begin
         valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_addr    <= addr;
                  r_cnt     <= '0;
                  r_state   <= HDR;
                  busy      <= 1'b1;
                  icap_csib <= 1'b0;
                  icap_i    <= pinWord(hdrWord(4'd0, addr));
               end
            end
            HDR: begin
               if (r_cnt == 4'd5) begin
                  r_cnt      <= '0;
                  r_state    <= SW_RD;
                  icap_csib  <= 1'b1;
                  icap_rdwrb <= 1'b1;
                  icap_i     <= '0;
               end else begin
                  r_cnt  <= r_cnt + 4'd1;
                  icap_i <= pinWord(hdrWord(r_cnt + 4'd1, r_addr));
               end
            end
            SW_RD: begin
               r_state   <= RD;
               icap_csib <= 1'b0;
            end
            // icap_o is sampled on the edge that ends the last read cycle
            RD: begin
               if (r_cnt == 4'(RD_LAT - 1)) begin
                  r_cnt      <= '0;
                  r_rdData   <= w_icapOData;
                  r_state    <= SW_WR;
                  icap_csib  <= 1'b1;
                  icap_rdwrb <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            SW_WR: begin
               r_state   <= DSYNC;
               icap_csib <= 1'b0;
               icap_i    <= pinWord(dsyncWord(4'd0));
            end
            DSYNC: begin
               if (r_cnt == 4'd3) begin
                  r_cnt     <= '0;
                  r_state   <= DONE;
                  icap_csib <= 1'b1;
                  icap_i    <= '0;
                  busy      <= 1'b0;
                  valid     <= 1'b1;
                  o         <= r_rdData;
               end else begin
                  r_cnt  <= r_cnt + 4'd1;
                  icap_i <= pinWord(dsyncWord(r_cnt + 4'd1));
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/icap_read.md
ICAP_READ -- requirements
Module: icap_read

Interface
REQ-001 SHALL have parameter RD_LAT, default 4, meaning the number of read-mode cycles (CSIB low, RDWRB high) before icap_o is captured; legal range 1..15.
REQ-002 SHALL have port c  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request one configuration register read; sampled only in IDLE.
REQ-005 SHALL have port addr  input  5  configuration register address, latched on accepted start.
REQ-006 SHALL have port busy  output  1  high while a transaction is in progress.
REQ-007 SHALL have port valid  output  1  one-cycle pulse: o holds the new read result.
REQ-008 SHALL have port o  output  32  read result in natural bit order, held until the next valid.
REQ-009 SHALL have ports icap_csib  output  1, icap_rdwrb  output  1, and icap_i  output  32, each registered and driving the ICAPE2 (X32) pins of the same names.
REQ-010 SHALL have port icap_o  input  32  ICAPE2 O pin.

Function
REQ-011 SHALL implement states IDLE, HDR, SW_RD, RD, SW_WR, DSYNC, DONE.
REQ-012 IDLE: csib=1, rdwrb=0; start=1 latches addr and enters HDR at the next edge, so busy rises 1 cycle after start is sampled.
REQ-013 HDR: 6 cycles, csib=0, rdwrb=0, words in order 0xFFFFFFFF, 0xAA995566, 0x20000000, 0x28000001|(addr<<13), 0x20000000, 0x20000000.
REQ-014 SW_RD: 1 cycle, csib=1, rdwrb=1; rdwrb SHALL change only while csib=1.
REQ-015 RD: RD_LAT cycles, csib=0, rdwrb=1; icap_o captured on the edge ending the last RD cycle.
REQ-016 SW_WR: 1 cycle, csib=1, rdwrb=0.
REQ-017 DSYNC: 4 cycles, csib=0, rdwrb=0, words 0x30008001, 0x0000000D, 0x20000000, 0x20000000.
REQ-018 DONE: 1 cycle, csib=1, valid=1, busy=0, o updated; then IDLE.
REQ-019 Start sampled at edge T -> valid high in cycle T+13+RD_LAT; back-to-back start accepted in the cycle after DONE.
REQ-020 start outside IDLE SHALL be ignored; addr changes outside IDLE SHALL have no effect.
REQ-021 icap_i SHALL be 0 whenever csib=1.
REQ-022 A 4-bit counter SHALL sequence HDR, RD and DSYNC words; no other wrap behaviour exists.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, icap_csib=1, icap_rdwrb=0, icap_i=0, busy=0, valid=0, o=0, counter=0.
REQ-024 Reset mid-transaction SHALL abort without issuing DSYNC; the next transaction resends the full HDR sequence.

Configuration
REQ-025 Macro ICAP_READ_BITSWAP_EN defined: icap_i SHALL carry each byte bit-reversed (bit 7<->0 per byte, byte order unchanged) and icap_o SHALL be un-reversed the same way before capture into o, as ICAPE2 requires.
REQ-026 Macro ICAP_READ_BITSWAP_EN undefined: icap_i and icap_o SHALL pass unmodified, for behavioural ICAP models.

Verification
REQ-027 Reset asserted then released, no start -> csib=1, rdwrb=0, icap_i=0, busy=0, valid=0, o=0 for 20 cycles.
REQ-028 Macro defined, RD_LAT=4, start with addr=0x0C, model drives icap_o=0xC0A608C9 in RD -> icap_i sequence 0xFFFFFFFF, 0x5599AA66, 0x04000000, 0x14800180, 0x04000000, 0x04000000; valid at T+17 with o=0x03651093.
REQ-029 Macro undefined, addr=0x07 -> fourth HDR word 0x2800E001, DSYNC words 0x30008001, 0x0000000D, 0x20000000, 0x20000000 verbatim.
REQ-030 start pulsed with addr=0x0C at T+3 of a transaction using addr=0x07 -> ignored; exactly one valid pulse; header used 0x07.
REQ-031 rst_n low during RD cycle 2 -> csib=1, rdwrb=0 same cycle, no valid; subsequent start completes normally with correct o.
REQ-032 Every cycle, checker asserts rdwrb transitions occur only with csib=1 and csib=1 implies icap_i=0.
